// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundle of every handshake/bus signal around the operand
// fetch stage.
//   decode side   : id_valid/id_ready, id_ra/id_rb, id_use_a/id_use_b,
//                   id_wc, id_we, id_load, id_opc, id_imm
//   bank side     : ra/rb (read addr), pra/prb (read data),
//                   wc/wpc/w_rb (snooped write port)
//   execute side  : exr_* (instruction currently in execute), flush,
//                   ex_valid/ex_ready, ex_opa/ex_opb, ex_wc/ex_we/ex_load/
//                   ex_opc/ex_imm
//   status        : stall_cnt (saturating load-use stall cycles)
// slave = the operand fetch stage, master = its environment.
interface operand_fetch_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int OPC_W  = 6,
    parameter int IMM_W  = 16
);
    logic              id_valid, id_ready;
    logic [REG_AW-1:0] id_ra, id_rb;
    logic              id_use_a, id_use_b;
    logic [REG_AW-1:0] id_wc;
    logic              id_we, id_load;
    logic [OPC_W-1:0]  id_opc;
    logic [IMM_W-1:0]  id_imm;

    logic [REG_AW-1:0] ra, rb;
    logic [DATA_W-1:0] pra, prb;
    logic [REG_AW-1:0] wc;
    logic [DATA_W-1:0] wpc;
    logic              w_rb;

    logic              exr_valid, exr_we, exr_load;
    logic [REG_AW-1:0] exr_wc;
    logic [DATA_W-1:0] exr_data;
    logic              flush;

    logic              ex_valid, ex_ready;
    logic [DATA_W-1:0] ex_opa, ex_opb;
    logic [REG_AW-1:0] ex_wc;
    logic              ex_we, ex_load;
    logic [OPC_W-1:0]  ex_opc;
    logic [IMM_W-1:0]  ex_imm;
    logic [15:0]       stall_cnt;

    modport slave (
        input  id_valid, id_ra, id_rb, id_use_a, id_use_b, id_wc, id_we,
               id_load, id_opc, id_imm, pra, prb, wc, wpc, w_rb,
               exr_valid, exr_we, exr_load, exr_wc, exr_data, flush, ex_ready,
        output id_ready, ra, rb, ex_valid, ex_opa, ex_opb, ex_wc, ex_we,
               ex_load, ex_opc, ex_imm, stall_cnt
    );

    modport master (
        output id_valid, id_ra, id_rb, id_use_a, id_use_b, id_wc, id_we,
               id_load, id_opc, id_imm, pra, prb, wc, wpc, w_rb,
               exr_valid, exr_we, exr_load, exr_wc, exr_data, flush, ex_ready,
        input  id_ready, ra, rb, ex_valid, ex_opa, ex_opb, ex_wc, ex_we,
               ex_load, ex_opc, ex_imm, stall_cnt
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: pipeline stage between decode and execute. Drives the bank
// read addresses, forwards from execute / the bank write port, stalls on
// load-use hazards and registers operands plus pass-through fields.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : operand_fetch_if.slave (see interface header for signal list)
// Optional build macro R0_ZERO_EN: register 0 reads as zero, is never
// forwarded and never causes a load-use hazard.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int OPC_W  = 6,
    parameter int IMM_W  = 16
) (
    input logic            clk,
    input logic            reset,
    operand_fetch_if.slave bus
);
`ifdef R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic              exr_alu;   // execute holds a forwardable ALU result
    logic              a_is_r0, b_is_r0;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] opa_sel, opb_sel;

    assign bus.ra = bus.id_ra;
    assign bus.rb = bus.id_rb;

    assign a_is_r0 = R0_ZERO && (bus.id_ra == '0);
    assign b_is_r0 = R0_ZERO && (bus.id_rb == '0);
    assign exr_alu = bus.exr_valid && bus.exr_we && !bus.exr_load;

    // Load data is not available until after execute, so a dependent
    // instruction must wait here rather than forward.
    assign hazard = bus.id_valid && bus.exr_valid && bus.exr_we && bus.exr_load &&
                    ((bus.id_use_a && !a_is_r0 && bus.exr_wc == bus.id_ra) ||
                     (bus.id_use_b && !b_is_r0 && bus.exr_wc == bus.id_rb));

    assign bus.id_ready = !hazard && !bus.flush && (!bus.ex_valid || bus.ex_ready);
    assign accept       = bus.id_valid && bus.id_ready;

    // Assignments run oldest-to-youngest so the youngest producer overrides:
    // bank, then write port (lands at this edge), then execute result.
    always_comb begin
        opa_sel = bus.pra;
        if (bus.w_rb && bus.wc == bus.id_ra)  opa_sel = bus.wpc;
        if (exr_alu && bus.exr_wc == bus.id_ra) opa_sel = bus.exr_data;
        if (a_is_r0)                            opa_sel = '0;
    end

    always_comb begin
        opb_sel = bus.prb;
        if (bus.w_rb && bus.wc == bus.id_rb)  opb_sel = bus.wpc;
        if (exr_alu && bus.exr_wc == bus.id_rb) opb_sel = bus.exr_data;
        if (b_is_r0)                            opb_sel = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_opa    <= '0;
            bus.ex_opb    <= '0;
            bus.ex_wc     <= '0;
            bus.ex_we     <= 1'b0;
            bus.ex_load   <= 1'b0;
            bus.ex_opc    <= '0;
            bus.ex_imm    <= '0;
            bus.stall_cnt <= '0;
        end else begin
            if (hazard && !bus.flush && bus.stall_cnt != 16'hFFFF)
                bus.stall_cnt <= bus.stall_cnt + 16'd1;

            if (bus.flush) begin
                bus.ex_valid <= 1'b0;
            end else if (accept) begin
                bus.ex_valid <= 1'b1;
                bus.ex_opa   <= opa_sel;
                bus.ex_opb   <= opb_sel;
                bus.ex_wc    <= bus.id_wc;
                bus.ex_we    <= bus.id_we;
                bus.ex_load  <= bus.id_load;
                bus.ex_opc   <= bus.id_opc;
                bus.ex_imm   <= bus.id_imm;
            end else if (bus.ex_valid && bus.ex_ready) begin
                // drained with nothing to replace it: bubble
                bus.ex_valid <= 1'b0;
            end
            // otherwise hold: payload registers keep their value
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a randomized run checked against
// a cycle-level reference model of the stage's rules.
module tb_operand_fetch;
    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 6;
    localparam int IMM_W  = 16;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    operand_fetch_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OPC_W(OPC_W), .IMM_W(IMM_W)) bus ();

    operand_fetch #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OPC_W(OPC_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        bus.id_valid = 0; bus.id_ra = 0; bus.id_rb = 0; bus.id_use_a = 0; bus.id_use_b = 0;
        bus.id_wc = 0; bus.id_we = 0; bus.id_load = 0; bus.id_opc = 0; bus.id_imm = 0;
        bus.pra = 0; bus.prb = 0; bus.wc = 0; bus.wpc = 0; bus.w_rb = 0;
        bus.exr_valid = 0; bus.exr_we = 0; bus.exr_load = 0; bus.exr_wc = 0; bus.exr_data = 0;
        bus.flush = 0; bus.ex_ready = 1;
    endtask

    task automatic test_reset;
        set_idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        vectors++;
        if ({bus.ex_valid, bus.ex_opa, bus.ex_opb, bus.ex_wc, bus.ex_we, bus.ex_load,
             bus.ex_opc, bus.ex_imm} !== '0) begin
            errors++; $display("FAIL reset_regs: ex_valid=%0b opa=%h opb=%h", bus.ex_valid, bus.ex_opa, bus.ex_opb);
        end
        vectors++;
        if (bus.stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt);
        end
        vectors++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.id_ready);
        end
    endtask

    task automatic test_basic;
        set_idle();
        bus.id_valid = 1; bus.id_ra = 3; bus.id_rb = 4; bus.pra = 32'h11; bus.prb = 32'h22;
        bus.id_wc = 9; bus.id_we = 1; bus.id_opc = 6'h2a; bus.id_imm = 16'h1357;
        #1;
        vectors++;
        if (bus.ra !== 4'd3 || bus.rb !== 4'd4) begin
            errors++; $display("FAIL basic_addr: ra=%0d rb=%0d want 3 4", bus.ra, bus.rb);
        end
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'h11 || bus.ex_opb !== 32'h22) begin
            errors++; $display("FAIL basic_ops: v=%b opa=%h opb=%h want 1 11 22", bus.ex_valid, bus.ex_opa, bus.ex_opb);
        end
        vectors++;
        if (bus.ex_wc !== 4'd9 || bus.ex_we !== 1'b1 || bus.ex_opc !== 6'h2a || bus.ex_imm !== 16'h1357) begin
            errors++; $display("FAIL basic_passthru: wc=%0d we=%b opc=%h imm=%h", bus.ex_wc, bus.ex_we, bus.ex_opc, bus.ex_imm);
        end
        bus.id_valid = 0;
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: ex_valid=%b want 0", bus.ex_valid);
        end
    endtask

    task automatic test_forward;
        set_idle();
        bus.id_valid = 1; bus.id_ra = 5; bus.id_rb = 6; bus.pra = 0; bus.prb = 32'h66;
        bus.w_rb = 1; bus.wc = 5; bus.wpc = 32'hDEAD;
        tick();
        vectors++;
        if (bus.ex_opa !== 32'hDEAD || bus.ex_opb !== 32'h66) begin
            errors++; $display("FAIL fwd_wport: opa=%h opb=%h want dead 66", bus.ex_opa, bus.ex_opb);
        end
        // execute and write port both target r5; both sources read r5
        bus.id_rb = 5; bus.prb = 0;
        bus.exr_valid = 1; bus.exr_we = 1; bus.exr_wc = 5; bus.exr_data = 32'hBEEF;
        tick();
        vectors++;
        if (bus.ex_opa !== 32'hBEEF || bus.ex_opb !== 32'hBEEF) begin
            errors++; $display("FAIL fwd_exec: opa=%h opb=%h want beef beef", bus.ex_opa, bus.ex_opb);
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use;
        set_idle();
        bus.id_valid = 1; bus.id_ra = 1; bus.pra = 32'h10;
        tick();                                   // ex_valid now 1
        bus.id_ra = 7; bus.id_use_a = 1; bus.id_imm = 16'hABCD; bus.id_opc = 6'h05;
        bus.exr_valid = 1; bus.exr_we = 1; bus.exr_load = 1; bus.exr_wc = 7;
        #1;
        vectors++;
        if (bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL lu_ready: got %b want 0", bus.id_ready);
        end
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_bubble: v=%b stall=%0d want 0 1", bus.ex_valid, bus.stall_cnt);
        end
        // load now writing back through the bank port
        bus.exr_valid = 0; bus.exr_load = 0; bus.w_rb = 1; bus.wc = 7; bus.wpc = 32'h77;
        #1;
        vectors++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL lu_resume_ready: got %b want 1", bus.id_ready);
        end
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'h77 || bus.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_resume: v=%b opa=%h stall=%0d want 1 77 1", bus.ex_valid, bus.ex_opa, bus.stall_cnt);
        end
    endtask

    task automatic test_backpressure;
        set_idle();
        bus.ex_ready = 0; bus.id_valid = 1; bus.id_ra = 2; bus.pra = 32'h1234; bus.id_imm = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.id_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.id_ready);
            end
            tick();
            vectors++;
            if (bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'h77 || bus.ex_imm !== 16'hABCD || bus.ex_opc !== 6'h05) begin
                errors++; $display("FAIL bp_hold[%0d]: v=%b opa=%h imm=%h opc=%h", i, bus.ex_valid, bus.ex_opa, bus.ex_imm, bus.ex_opc);
            end
        end
        bus.ex_ready = 1;
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'h1234 || bus.ex_imm !== 16'h4444) begin
            errors++; $display("FAIL bp_release: v=%b opa=%h imm=%h", bus.ex_valid, bus.ex_opa, bus.ex_imm);
        end
    endtask

    task automatic test_flush;
        set_idle();
        bus.flush = 1; bus.id_valid = 1; bus.id_ra = 8; bus.pra = 32'h88;
        #1;
        vectors++;
        if (bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b want 0", bus.id_ready);
        end
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL flush_kill: ex_valid=%b want 0", bus.ex_valid);
        end
        bus.flush = 0; bus.ex_ready = 0;
        tick();                                   // accepted, then held
        tick();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'h88) begin
            errors++; $display("FAIL flush_refill: v=%b opa=%h", bus.ex_valid, bus.ex_opa);
        end
        reset = 1;
        tick();
        reset = 0;
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_opa !== '0 || bus.ex_imm !== '0 || bus.stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_midhold: v=%b opa=%h stall=%0d", bus.ex_valid, bus.ex_opa, bus.stall_cnt);
        end
    endtask

    task automatic test_r0;
        logic [DATA_W-1:0] exp_a;
        set_idle();
        bus.id_valid = 1; bus.id_ra = 0; bus.pra = 32'h55; bus.w_rb = 1; bus.wc = 0; bus.wpc = 32'h99;
        exp_a = R0 ? 32'h0 : 32'h99;
        tick();
        vectors++;
        if (bus.ex_opa !== exp_a) begin
            errors++; $display("FAIL r0_read: opa=%h want %h", bus.ex_opa, exp_a);
        end
        set_idle();
        bus.id_valid = 1; bus.id_ra = 0; bus.id_use_a = 1;
        bus.exr_valid = 1; bus.exr_we = 1; bus.exr_load = 1; bus.exr_wc = 0;
        #1;
        vectors++;
        if (bus.id_ready !== R0) begin
            errors++; $display("FAIL r0_hazard: id_ready=%b want %b", bus.id_ready, R0);
        end
        set_idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Reference: the spec's rules evaluated directly each cycle.
    task automatic test_random;
        logic              m_valid;
        logic [DATA_W-1:0] m_opa, m_opb;
        logic [REG_AW-1:0] m_wc;
        logic              m_we, m_load;
        logic [OPC_W-1:0]  m_opc;
        logic [IMM_W-1:0]  m_imm;
        int                m_stall;
        logic              hz, rdy;
        m_valid = 0; m_opa = 0; m_opb = 0; m_wc = 0; m_we = 0; m_load = 0; m_opc = 0; m_imm = 0;
        m_stall = 0;
        for (int n = 0; n < 600; n++) begin
            bus.id_valid  = ($urandom_range(0, 3) != 0);
            bus.id_ra     = REG_AW'($urandom_range(0, 3));
            bus.id_rb     = REG_AW'($urandom_range(0, 3));
            bus.id_use_a  = $urandom_range(0, 1);
            bus.id_use_b  = $urandom_range(0, 1);
            bus.id_wc     = REG_AW'($urandom);
            bus.id_we     = $urandom_range(0, 1);
            bus.id_load   = $urandom_range(0, 1);
            bus.id_opc    = OPC_W'($urandom);
            bus.id_imm    = IMM_W'($urandom);
            bus.pra       = $urandom; bus.prb = $urandom;
            bus.wc        = REG_AW'($urandom_range(0, 3));
            bus.wpc       = $urandom;
            bus.w_rb      = $urandom_range(0, 1);
            bus.exr_valid = $urandom_range(0, 1);
            bus.exr_we    = $urandom_range(0, 1);
            bus.exr_load  = ($urandom_range(0, 3) == 0);
            bus.exr_wc    = REG_AW'($urandom_range(0, 3));
            bus.exr_data  = $urandom;
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.ex_ready  = ($urandom_range(0, 2) != 0);

            hz = bus.id_valid && bus.exr_valid && bus.exr_we && bus.exr_load &&
                 ((bus.id_use_a && bus.exr_wc == bus.id_ra && !(R0 && bus.id_ra == 0)) ||
                  (bus.id_use_b && bus.exr_wc == bus.id_rb && !(R0 && bus.id_rb == 0)));
            rdy = !hz && !bus.flush && (!m_valid || bus.ex_ready);
            #1;
            vectors++;
            if (bus.id_ready !== rdy || bus.ra !== bus.id_ra || bus.rb !== bus.id_rb) begin
                errors++; $display("FAIL rnd_comb[%0d]: ready=%b want %b", n, bus.id_ready, rdy);
            end

            if (hz && !bus.flush && m_stall < 16'hFFFF) m_stall++;
            if (bus.flush) m_valid = 0;
            else if (bus.id_valid && rdy) begin
                m_valid = 1;
                m_opa = pick(bus.id_ra, bus.pra);
                m_opb = pick(bus.id_rb, bus.prb);
                m_wc = bus.id_wc; m_we = bus.id_we; m_load = bus.id_load;
                m_opc = bus.id_opc; m_imm = bus.id_imm;
            end else if (m_valid && bus.ex_ready) m_valid = 0;

            tick();
            vectors++;
            if (bus.ex_valid !== m_valid || bus.stall_cnt !== 16'(m_stall) ||
                bus.ex_opa !== m_opa || bus.ex_opb !== m_opb || bus.ex_wc !== m_wc ||
                bus.ex_we !== m_we || bus.ex_load !== m_load || bus.ex_opc !== m_opc ||
                bus.ex_imm !== m_imm) begin
                errors++;
                $display("FAIL rnd_state[%0d]: v=%b/%b opa=%h/%h opb=%h/%h stall=%0d/%0d",
                         n, bus.ex_valid, m_valid, bus.ex_opa, m_opa, bus.ex_opb, m_opb,
                         bus.stall_cnt, m_stall);
            end
        end
    endtask

    // Value an instruction sees for a source: youngest producer first.
    function automatic logic [DATA_W-1:0] pick(input logic [REG_AW-1:0] src, input logic [DATA_W-1:0] bank);
        if (R0 && src == 0) return '0;
        if (bus.exr_valid && bus.exr_we && !bus.exr_load && bus.exr_wc == src) return bus.exr_data;
        if (bus.w_rb && bus.wc == src) return bus.wpc;
        return bank;
    endfunction

    initial begin
        reset = 1;
        set_idle();
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_r0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
